// File: rtl/sdio_fbr_if.sv
// Host-side CIA access bus shared by the CIA decoder (master) and the FBR bank (slave).
interface sdio_fbr_if;
  logic        i_activate;
  logic        i_write_flag;
  logic [16:0] i_address;
  logic        i_data_stb;
  logic [7:0]  i_data_in;
  logic [7:0]  o_data_out;
  logic        o_data_rdy;
  logic        o_busy;
  logic        o_err;

  modport slave (
    input  i_activate, i_write_flag, i_address, i_data_stb, i_data_in,
    output o_data_out, o_data_rdy, o_busy, o_err
  );

  modport master (
    output i_activate, i_write_flag, i_address, i_data_stb, i_data_in,
    input  o_data_out, o_data_rdy, o_busy, o_err
  );
endinterface

// File: rtl/sdio_fbr_bank.sv
// Function Basic Register bank for SDIO functions 1..NUM_FUNCS, with staged
// block-size commits and a handshaked CSA window to an external store.
module sdio_fbr_bank #(
  parameter int          NUM_FUNCS          = 2,
  parameter logic [27:0] FUNC_TYPES         = 28'h0,
  parameter logic [6:0]  CSA_SUPPORT        = 7'h0,
  parameter logic [6:0]  PWR_SEL_SUPPORT    = 7'h0,
  parameter logic [23:0] CIS_BASE           = 24'h001000,
  parameter logic [23:0] CIS_STRIDE         = 24'h000100,
  parameter logic [15:0] DEFAULT_BLOCK_SIZE = 16'd256,
  parameter logic [15:0] MAX_BLOCK_SIZE     = 16'd2048,
  parameter int          CSA_TIMEOUT        = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  sdio_fbr_if.slave               bus,
  output logic [NUM_FUNCS-1:0]    o_csa_en,
  output logic [NUM_FUNCS-1:0]    o_pwr_mode,
  output logic [16*NUM_FUNCS-1:0] o_block_size,
  output logic [2:0]              o_csa_func,
  output logic [23:0]             o_csa_addr,
  output logic                    o_csa_rd,
  output logic                    o_csa_wr,
  output logic [7:0]              o_csa_data,
  input  logic [7:0]              i_csa_data,
  input  logic                    i_csa_ack
);

  localparam int TMO_W = $clog2(CSA_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t               r_state;
  logic [TMO_W-1:0]     r_tmo;
  logic [7:0]           r_data_out;
  logic                 r_data_rdy;
  logic                 r_busy;
  logic                 r_err;
  logic [2:0]           r_csa_func;
  logic [23:0]          r_csa_addr;
  logic                 r_csa_rd;
  logic                 r_csa_wr;
  logic [7:0]           r_csa_data;
  logic [NUM_FUNCS-1:0] r_csa_en;
  logic [NUM_FUNCS-1:0] r_eps;
  logic [15:0]          r_block_size [NUM_FUNCS];
  logic [7:0]           r_bs_lo      [NUM_FUNCS];
  logic [23:0]          r_csa_ptr    [NUM_FUNCS];

  logic [2:0]  w_func;
  logic [7:0]  w_off;
  logic        w_valid;
  logic        w_stb;
  logic [7:0]  w_rd_data;
  logic        w_sel_csa_en;
  logic [23:0] w_sel_ptr;
  logic [7:0]  w_sel_lo;
  logic [23:0] w_cis;
  logic [15:0] w_commit;
  logic        w_commit_ok;

  function automatic logic [23:0] cis_ptr(input int idx);
    logic [31:0] v;
    v = 32'(CIS_BASE) + 32'(idx) * 32'(CIS_STRIDE);
    return v[23:0];
  endfunction

  assign w_func      = bus.i_address[10:8];
  assign w_off       = bus.i_address[7:0];
  assign w_valid     = (bus.i_address[16:11] == 6'd0) && (w_func != 3'd0) &&
                       (int'(w_func) <= NUM_FUNCS);
  assign w_stb       = bus.i_activate && bus.i_data_stb;
  assign w_commit    = {bus.i_data_in, w_sel_lo};
  assign w_commit_ok = (w_commit != 16'd0) && (w_commit <= MAX_BLOCK_SIZE);

  // NOTE: every variable driven here gets a default first so no path infers a latch.
  always_comb begin
    w_rd_data    = 8'h00;
    w_sel_csa_en = 1'b0;
    w_sel_ptr    = 24'd0;
    w_sel_lo     = 8'h00;
    w_cis        = 24'd0;
    for (int f = 0; f < NUM_FUNCS; f++) begin
      if (w_valid && w_func == 3'(f + 1)) begin
        w_sel_csa_en = r_csa_en[f];
        w_sel_ptr    = r_csa_ptr[f];
        w_sel_lo     = r_bs_lo[f];
        w_cis        = cis_ptr(f);
        case (w_off)
          8'h00:   w_rd_data = {r_csa_en[f], CSA_SUPPORT[f], 2'b00, FUNC_TYPES[4*f +: 4]};
          8'h02:   w_rd_data = {6'b0, r_eps[f], PWR_SEL_SUPPORT[f]};
          8'h09:   w_rd_data = w_cis[7:0];
          8'h0A:   w_rd_data = w_cis[15:8];
          8'h0B:   w_rd_data = w_cis[23:16];
          8'h0C:   w_rd_data = r_csa_ptr[f][7:0];
          8'h0D:   w_rd_data = r_csa_ptr[f][15:8];
          8'h0E:   w_rd_data = r_csa_ptr[f][23:16];
          8'h10:   w_rd_data = r_block_size[f][7:0];
          8'h11:   w_rd_data = r_block_size[f][15:8];
          default: w_rd_data = 8'h00;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_data_out <= 8'h00;
      r_data_rdy <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_csa_func <= 3'd0;
      r_csa_addr <= 24'd0;
      r_csa_rd   <= 1'b0;
      r_csa_wr   <= 1'b0;
      r_csa_data <= 8'h00;
      r_csa_en   <= '0;
      r_eps      <= '0;
      // NOTE: these small per-function arrays are software-visible registers, not
      // RAM, so they are reset like any other flop.
      for (int f = 0; f < NUM_FUNCS; f++) begin
        r_block_size[f] <= DEFAULT_BLOCK_SIZE;
        r_bs_lo[f]      <= 8'h00;
        r_csa_ptr[f]    <= 24'd0;
      end
    end else begin
      r_data_rdy <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_stb) begin
            if (w_valid && w_off == 8'h0F && w_sel_csa_en) begin
              r_state    <= bus.i_write_flag ? S_WR : S_RD;
              r_busy     <= 1'b1;
              r_tmo      <= '0;
              r_csa_func <= w_func;
              r_csa_addr <= w_sel_ptr;
              r_csa_rd   <= !bus.i_write_flag;
              r_csa_wr   <= bus.i_write_flag;
              r_csa_data <= bus.i_write_flag ? bus.i_data_in : 8'h00;
            end else begin
              r_data_rdy <= 1'b1;
              r_data_out <= bus.i_write_flag ? 8'h00 : w_rd_data;
              if (!w_valid) begin
                r_err <= bus.i_write_flag;
              end else if (w_off == 8'h0F) begin
                r_err <= 1'b1;
              end else if (bus.i_write_flag) begin
                for (int f = 0; f < NUM_FUNCS; f++) begin
                  if (w_func == 3'(f + 1)) begin
                    case (w_off)
                      8'h00: if (CSA_SUPPORT[f]) r_csa_en[f] <= bus.i_data_in[7];
                      8'h02: if (PWR_SEL_SUPPORT[f]) r_eps[f] <= bus.i_data_in[1];
                      8'h0C: r_csa_ptr[f][7:0]   <= bus.i_data_in;
                      8'h0D: r_csa_ptr[f][15:8]  <= bus.i_data_in;
                      8'h0E: r_csa_ptr[f][23:16] <= bus.i_data_in;
                      8'h10: r_bs_lo[f]          <= bus.i_data_in;
                      8'h11: begin
                        if (w_commit_ok) r_block_size[f] <= w_commit;
                        else             r_err           <= 1'b1;
                      end
                      default: ;
                    endcase
                  end
                end
              end
            end
          end
        end

        S_RD, S_WR: begin
          if (w_stb) r_err <= 1'b1;
          if (i_csa_ack || r_tmo == TMO_W'(CSA_TIMEOUT - 1)) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_csa_func <= 3'd0;
            r_csa_addr <= 24'd0;
            r_csa_rd   <= 1'b0;
            r_csa_wr   <= 1'b0;
            r_csa_data <= 8'h00;
            r_data_rdy <= 1'b1;
            if (i_csa_ack) begin
              if (r_state == S_RD) r_data_out <= i_csa_data;
              for (int f = 0; f < NUM_FUNCS; f++) begin
                if (r_csa_func == 3'(f + 1)) r_csa_ptr[f] <= r_csa_ptr[f] + 24'd1;
              end
            end else begin
              // Timed out: report an error and leave the pointer where it was.
              r_err <= 1'b1;
              if (r_state == S_RD) r_data_out <= 8'hFF;
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_block_size = '0;
    for (int f = 0; f < NUM_FUNCS; f++) o_block_size[16*f +: 16] = r_block_size[f];
  end

  assign bus.o_data_out = r_data_out;
  assign bus.o_data_rdy = r_data_rdy;
  assign bus.o_busy     = r_busy;
  assign bus.o_err      = r_err;
  assign o_csa_en       = r_csa_en;
  assign o_pwr_mode     = r_eps;
  assign o_csa_func     = r_csa_func;
  assign o_csa_addr     = r_csa_addr;
  assign o_csa_rd       = r_csa_rd;
  assign o_csa_wr       = r_csa_wr;
  assign o_csa_data     = r_csa_data;

endmodule
